// File: rtl/data_mem_responder.sv
// Data-side memory target for the MEM stage: byte-lane word RAM with
// combinational extended loads, plus a small memory-mapped I/O window.
module data_mem_responder #(
  parameter int          DEPTH     = 1024,
  parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_w,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [2:0]  dm_type,
  output logic [31:0] rdata,
  input  logic [15:0] sw_in,
  output logic [15:0] led_out,
  output logic [31:0] seg_out,
  output logic        timer_hit,
  output logic        misalign_err
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [2:0] DM_WORD   = 3'd0;
  localparam logic [2:0] DM_HALF   = 3'd1;
  localparam logic [2:0] DM_HALF_U = 3'd2;
  localparam logic [2:0] DM_BYTE   = 3'd3;
  localparam logic [2:0] DM_BYTE_U = 3'd4;

  localparam logic [15:0] OFF_LED    = 16'h0000;
  localparam logic [15:0] OFF_SEG    = 16'h0004;
  localparam logic [15:0] OFF_SW     = 16'h0008;
  localparam logic [15:0] OFF_CYCLE  = 16'h000C;
  localparam logic [15:0] OFF_TCMP   = 16'h0010;
  localparam logic [15:0] OFF_STATUS = 16'h0014;

  localparam logic [32:0] RAM_BYTES = 33'(DEPTH) << 2;

  logic          ram_sel;
  logic          mmio_sel;
  logic          is_byte;
  logic          is_half;
  logic          is_word;
  logic          ram_misalign;
  logic          ram_we;
  logic          mmio_we;
  logic          misalign_set;
  logic          timer_set;
  logic [3:0]    lane_mask;
  logic [31:0]   wdata_rep;
  logic [AW-1:0] word_idx;
  logic [31:0]   ram_word;
  logic [7:0]    byte_sel;
  logic [15:0]   half_sel;
  logic [31:0]   ram_load;
  logic [31:0]   mmio_rdata;

  logic [15:0] led_reg,     led_next;
  logic [31:0] seg_reg,     seg_next;
  logic [31:0] cycle_reg,   cycle_next;
  logic [31:0] tcmp_reg,    tcmp_next;
  logic [1:0]  status_reg,  status_next;
  logic [15:0] sw_meta_reg;
  logic [15:0] sw_sync_reg;

  // RAM wins any overlap with the I/O window so a large DEPTH stays reachable.
  assign ram_sel  = ({1'b0, addr} < RAM_BYTES);
  assign mmio_sel = !ram_sel && (addr[31:16] == MMIO_BASE[31:16]);

  assign is_byte = (dm_type == DM_BYTE) || (dm_type == DM_BYTE_U);
  assign is_half = (dm_type == DM_HALF) || (dm_type == DM_HALF_U);
  assign is_word = !is_byte && !is_half;

  assign ram_misalign = (is_half && addr[0]) || (is_word && (addr[1:0] != 2'b00));
  assign ram_we       = mem_w && !rst && ram_sel && !ram_misalign;
  assign mmio_we      = mem_w && !rst && mmio_sel && is_word;
  assign misalign_set = mem_w && ((ram_sel && ram_misalign) || (mmio_sel && !is_word));
  assign timer_set    = (cycle_reg == tcmp_reg) && (tcmp_reg != 32'd0);

  assign word_idx = addr[AW+1:2];

  always_comb begin
    lane_mask = 4'b1111;
    wdata_rep = wdata;
    if (is_byte) begin
      lane_mask = 4'b0001 << addr[1:0];
      wdata_rep = {4{wdata[7:0]}};
    end else if (is_half) begin
      lane_mask = addr[1] ? 4'b1100 : 4'b0011;
      wdata_rep = {2{wdata[15:0]}};
    end
  end

  // One narrow array per byte lane keeps lane writes independent.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] lane_mem [DEPTH];

      always_ff @(posedge clk) begin
        if (ram_we && lane_mask[gi]) begin
          lane_mem[word_idx] <= wdata_rep[8*gi +: 8];
        end
      end

      assign ram_word[8*gi +: 8] = lane_mem[word_idx];
    end
  endgenerate

  always_comb begin
    case (addr[1:0])
      2'd0:    byte_sel = ram_word[7:0];
      2'd1:    byte_sel = ram_word[15:8];
      2'd2:    byte_sel = ram_word[23:16];
      default: byte_sel = ram_word[31:24];
    endcase
    half_sel = addr[1] ? ram_word[31:16] : ram_word[15:0];
    case (dm_type)
      DM_BYTE:   ram_load = {{24{byte_sel[7]}}, byte_sel};
      DM_BYTE_U: ram_load = {24'd0, byte_sel};
      DM_HALF:   ram_load = {{16{half_sel[15]}}, half_sel};
      DM_HALF_U: ram_load = {16'd0, half_sel};
      default:   ram_load = ram_word;
    endcase
  end

  always_comb begin
    case (addr[15:0])
      OFF_LED:    mmio_rdata = {16'd0, led_reg};
      OFF_SEG:    mmio_rdata = seg_reg;
      OFF_SW:     mmio_rdata = {16'd0, sw_sync_reg};
      OFF_CYCLE:  mmio_rdata = cycle_reg;
      OFF_TCMP:   mmio_rdata = tcmp_reg;
      OFF_STATUS: mmio_rdata = {30'd0, status_reg};
      default:    mmio_rdata = 32'd0;
    endcase
  end

  always_comb begin
    if (ram_sel) begin
      rdata = ram_load;
    end else if (mmio_sel) begin
      rdata = mmio_rdata;
    end else begin
      rdata = 32'd0;
    end
  end

  // The timer compare and the W1C clear both use pre-edge register values,
  // so a same-cycle TCMP store or clear cannot hide a match.
  always_comb begin
    led_next    = led_reg;
    seg_next    = seg_reg;
    tcmp_next   = tcmp_reg;
    cycle_next  = cycle_reg + 32'd1;
    status_next = status_reg;
    if (mmio_we) begin
      case (addr[15:0])
        OFF_LED:    led_next    = wdata[15:0];
        OFF_SEG:    seg_next    = wdata;
        OFF_CYCLE:  cycle_next  = wdata;
        OFF_TCMP:   tcmp_next   = wdata;
        OFF_STATUS: status_next = status_reg & ~wdata[1:0];
        default:    ;
      endcase
    end
    status_next = status_next | {misalign_set, timer_set};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      led_reg     <= 16'd0;
      seg_reg     <= 32'd0;
      cycle_reg   <= 32'd0;
      tcmp_reg    <= 32'd0;
      status_reg  <= 2'd0;
      sw_meta_reg <= 16'd0;
      sw_sync_reg <= 16'd0;
    end else begin
      led_reg     <= led_next;
      seg_reg     <= seg_next;
      cycle_reg   <= cycle_next;
      tcmp_reg    <= tcmp_next;
      status_reg  <= status_next;
      sw_meta_reg <= sw_in;
      sw_sync_reg <= sw_meta_reg;
    end
  end

  assign led_out      = led_reg;
  assign seg_out      = seg_reg;
  assign timer_hit    = status_reg[0];
  assign misalign_err = status_reg[1];

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomised and directed checks of data_mem_responder against a byte-addressed
// behavioural model of the RAM and the I/O registers.
module tb_data_mem_responder;

  localparam logic [2:0] T_W  = 3'd0;
  localparam logic [2:0] T_H  = 3'd1;
  localparam logic [2:0] T_HU = 3'd2;
  localparam logic [2:0] T_B  = 3'd3;
  localparam logic [2:0] T_BU = 3'd4;

  localparam logic [31:0] IO     = 32'hFFFF_0000;
  localparam logic [31:0] A_LED  = IO + 32'h00;
  localparam logic [31:0] A_SEG  = IO + 32'h04;
  localparam logic [31:0] A_SW   = IO + 32'h08;
  localparam logic [31:0] A_CYC  = IO + 32'h0C;
  localparam logic [31:0] A_TCMP = IO + 32'h10;
  localparam logic [31:0] A_STAT = IO + 32'h14;

  logic        clk;
  logic        rst;
  logic        mem_w;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [2:0]  dm_type;
  logic [31:0] rdata;
  logic [15:0] sw_in;
  logic [15:0] led_out;
  logic [31:0] seg_out;
  logic        timer_hit;
  logic        misalign_err;

  int n_tests;
  int n_fail;

  // Reference model state
  logic [7:0]  m_mem [256];
  logic [15:0] m_led;
  logic [31:0] m_seg;
  logic [31:0] m_cycle;
  logic [31:0] m_tcmp;
  logic        m_hit;
  logic        m_mis;
  logic [15:0] m_sw_hist [2];
  bit          model_valid;

  data_mem_responder #(.DEPTH(1024), .MMIO_BASE(32'hFFFF_0000)) dut (
    .clk(clk), .rst(rst), .mem_w(mem_w), .addr(addr), .wdata(wdata),
    .dm_type(dm_type), .rdata(rdata), .sw_in(sw_in), .led_out(led_out),
    .seg_out(seg_out), .timer_hit(timer_hit), .misalign_err(misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] a, input logic [2:0] t);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] w;
    b = m_mem[a[7:0]];
    h = {m_mem[{a[7:1], 1'b1}], m_mem[{a[7:1], 1'b0}]};
    w = {m_mem[{a[7:2], 2'd3}], m_mem[{a[7:2], 2'd2}], m_mem[{a[7:2], 2'd1}], m_mem[{a[7:2], 2'd0}]};
    if (a < 32'd4096) begin
      case (t)
        T_B:     return {{24{b[7]}}, b};
        T_BU:    return {24'd0, b};
        T_H:     return {{16{h[15]}}, h};
        T_HU:    return {16'd0, h};
        default: return w;
      endcase
    end else if (a[31:16] == 16'hFFFF) begin
      case (a[15:0])
        16'h00:  return {16'd0, m_led};
        16'h04:  return m_seg;
        16'h08:  return {16'd0, m_sw_hist[1]};
        16'h0C:  return m_cycle;
        16'h10:  return m_tcmp;
        16'h14:  return {30'd0, m_mis, m_hit};
        default: return 32'd0;
      endcase
    end
    return 32'd0;
  endfunction

  // Apply one rising edge worth of behaviour to the model.
  task automatic model_edge(input logic r, input logic w, input logic [31:0] a,
                            input logic [31:0] d, input logic [2:0] t, input logic [15:0] s);
    logic        hit_set, mis_set;
    logic [1:0]  clr;
    logic [31:0] new_cycle, new_tcmp;
    if (r) begin
      m_led = '0; m_seg = '0; m_cycle = '0; m_tcmp = '0; m_hit = 1'b0; m_mis = 1'b0;
      m_sw_hist[0] = '0; m_sw_hist[1] = '0;
      model_valid = 1'b1;
      return;
    end
    hit_set   = (m_tcmp != 0) && (m_cycle == m_tcmp);
    mis_set   = 1'b0;
    clr       = 2'b00;
    new_cycle = m_cycle + 1;
    new_tcmp  = m_tcmp;
    if (w) begin
      if (a < 32'd4096) begin
        if (t == T_B || t == T_BU) begin
          m_mem[a[7:0]] = d[7:0];
        end else if (t == T_H || t == T_HU) begin
          if (a % 2 != 0) mis_set = 1'b1;
          else begin
            m_mem[a[7:0]] = d[7:0];
            m_mem[a[7:0] + 8'd1] = d[15:8];
          end
        end else begin
          if (a % 4 != 0) mis_set = 1'b1;
          else for (int k = 0; k < 4; k++) m_mem[a[7:0] + 8'(k)] = d[8*k +: 8];
        end
      end else if (a[31:16] == 16'hFFFF) begin
        if (t != T_W) mis_set = 1'b1;
        else case (a[15:0])
          16'h00: m_led = d[15:0];
          16'h04: m_seg = d;
          16'h0C: new_cycle = d;
          16'h10: new_tcmp = d;
          16'h14: clr = d[1:0];
          default: ;
        endcase
      end
    end
    m_hit = (m_hit && !clr[0]) || hit_set;
    m_mis = (m_mis && !clr[1]) || mis_set;
    m_cycle = new_cycle;
    m_tcmp  = new_tcmp;
    m_sw_hist[1] = m_sw_hist[0];
    m_sw_hist[0] = s;
  endtask

  task automatic drive(input logic r, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [2:0] t);
    rst = r; mem_w = w; addr = a; wdata = d; dm_type = t;
    #3;
  endtask

  task automatic finish_cycle();
    @(posedge clk);
    #1;
    model_edge(rst, mem_w, addr, wdata, dm_type, sw_in);
    if (model_valid) begin
      check_eq("led_out", {16'd0, led_out}, {16'd0, m_led});
      check_eq("seg_out", seg_out, m_seg);
      check_eq("timer_hit", {31'd0, timer_hit}, {31'd0, m_hit});
      check_eq("misalign_err", {31'd0, misalign_err}, {31'd0, m_mis});
    end
  endtask

  task automatic step(input logic r, input logic w, input logic [31:0] a,
                      input logic [31:0] d, input logic [2:0] t, input bit chk_rd);
    drive(r, w, a, d, t);
    if (chk_rd && model_valid) check_eq("rdata_model", rdata, model_read(a, t));
    finish_cycle();
  endtask

  task automatic rd_expect(input string tag, input logic [31:0] a, input logic [2:0] t,
                           input logic [31:0] exp);
    drive(1'b0, 1'b0, a, 32'd0, t);
    check_eq("rdata_model", rdata, model_read(a, t));
    check_eq(tag, rdata, exp);
    finish_cycle();
  endtask

  initial begin
    int rises, rise_idx, tgt;
    logic prev_hit;
    n_tests = 0; n_fail = 0; model_valid = 1'b0;
    sw_in = 16'h0;
    drive(1'b1, 1'b0, 32'd0, 32'd0, T_W);
    finish_cycle();
    check_eq("reset_led", {16'd0, led_out}, 32'd0);
    check_eq("reset_seg", seg_out, 32'd0);
    check_eq("reset_status", {30'd0, misalign_err, timer_hit}, 32'd0);
    step(1'b1, 1'b0, 32'd0, 32'd0, T_W, 1'b1);
    rd_expect("reset_cycle", A_CYC, T_W, 32'd0);

    for (int i = 0; i < 64; i++) step(1'b0, 1'b1, 32'(i * 4), 32'hA000_0000 | 32'(i * 4), T_W, 1'b0);

    // Sub-word stores and extended loads
    step(1'b0, 1'b1, 32'h10, 32'h8000_00FF, T_W, 1'b1);
    step(1'b0, 1'b1, 32'h13, 32'h0000_0012, T_B, 1'b1);
    rd_expect("word_0x10", 32'h10, T_W, 32'h1200_00FF);
    rd_expect("byte_s_0x13", 32'h13, T_B, 32'h0000_0012);
    rd_expect("half_s_0x10", 32'h10, T_H, 32'h0000_00FF);
    step(1'b0, 1'b1, 32'h12, 32'h0000_8001, T_H, 1'b1);
    rd_expect("half_s_0x12", 32'h12, T_H, 32'hFFFF_8001);
    rd_expect("half_u_0x12", 32'h12, T_HU, 32'h0000_8001);
    rd_expect("byte_s_0x13b", 32'h13, T_B, 32'hFFFF_FF80);

    // Misaligned store suppressed and flagged, then cleared via W1C
    step(1'b0, 1'b1, 32'h22, 32'hDEAD_BEEF, T_W, 1'b1);
    check_eq("misalign_set", {31'd0, misalign_err}, 32'd1);
    rd_expect("misalign_mem", 32'h20, T_W, 32'hA000_0020);
    step(1'b0, 1'b1, A_STAT, 32'h2, T_W, 1'b1);
    check_eq("misalign_clr", {31'd0, misalign_err}, 32'd0);
    step(1'b0, 1'b1, A_LED, 32'h1234, T_B, 1'b1);
    check_eq("mmio_sub_word", {31'd0, misalign_err}, 32'd1);
    step(1'b0, 1'b1, A_STAT, 32'h2, T_W, 1'b1);

    // Unmapped region
    step(1'b0, 1'b1, 32'h4000_0000, 32'h5555_AAAA, T_W, 1'b1);
    rd_expect("unmapped_rd", 32'h4000_0000, T_W, 32'd0);
    rd_expect("above_ram_rd", 32'h0000_1000, T_W, 32'd0);
    check_eq("unmapped_noflag", {31'd0, misalign_err}, 32'd0);

    // Timer: single rise at CYCLE == 20, sticky until W1C
    step(1'b1, 1'b0, 32'd0, 32'd0, T_W, 1'b1);
    step(1'b0, 1'b1, A_TCMP, 32'd20, T_W, 1'b1);
    rises = 0; rise_idx = -1; prev_hit = timer_hit;
    for (int k = 1; k < 40; k++) begin
      step(1'b0, 1'b0, A_CYC, 32'd0, T_W, 1'b1);
      if (timer_hit && !prev_hit) begin rises++; rise_idx = k; end
      prev_hit = timer_hit;
    end
    check_eq("timer_rises", 32'(rises), 32'd1);
    check_eq("timer_rise_idx", 32'(rise_idx), 32'd20);
    check_eq("timer_sticky", {31'd0, timer_hit}, 32'd1);
    step(1'b0, 1'b1, A_STAT, 32'h1, T_W, 1'b1);
    check_eq("timer_w1c", {31'd0, timer_hit}, 32'd0);
    tgt = int'(m_cycle) + 4;
    step(1'b0, 1'b1, A_TCMP, 32'(tgt), T_W, 1'b1);
    for (int k = 0; k < 10 && m_cycle != 32'(tgt); k++) step(1'b0, 1'b0, A_CYC, 32'd0, T_W, 1'b1);
    step(1'b0, 1'b1, A_STAT, 32'h1, T_W, 1'b1);
    check_eq("timer_set_beats_clr", {31'd0, timer_hit}, 32'd1);
    step(1'b0, 1'b1, A_STAT, 32'h1, T_W, 1'b1);
    check_eq("timer_clr_after", {31'd0, timer_hit}, 32'd0);

    // CYCLE store and wrap
    step(1'b0, 1'b1, A_CYC, 32'hFFFF_FFFE, T_W, 1'b1);
    rd_expect("cycle_fffe", A_CYC, T_W, 32'hFFFF_FFFE);
    rd_expect("cycle_ffff", A_CYC, T_W, 32'hFFFF_FFFF);
    rd_expect("cycle_wrap", A_CYC, T_W, 32'h0000_0000);

    // Switch synchroniser latency
    sw_in = 16'hA5A5;
    rd_expect("sw_edge0", A_SW, T_B, 32'd0);
    rd_expect("sw_edge1", A_SW, T_B, 32'd0);
    rd_expect("sw_edge2", A_SW, T_B, 32'h0000_A5A5);

    // Reset during an LED store; RAM retained
    step(1'b0, 1'b1, A_LED, 32'h0000_00C3, T_W, 1'b1);
    step(1'b0, 1'b1, 32'h22, 32'd0, T_W, 1'b1);
    step(1'b1, 1'b1, A_LED, 32'h0000_BEEF, T_W, 1'b1);
    check_eq("rst_led", {16'd0, led_out}, 32'd0);
    rd_expect("rst_status", A_STAT, T_W, 32'd0);
    rd_expect("rst_ram_kept", 32'h10, T_W, 32'h8001_00FF);

    // Randomised traffic
    for (int n = 0; n < 1500; n++) begin
      logic        r, w;
      logic [31:0] a, d;
      logic [2:0]  t;
      int          sel;
      r   = ($urandom_range(0, 199) == 0);
      w   = 1'($urandom_range(0, 1));
      sel = $urandom_range(0, 9);
      t   = 3'($urandom_range(0, 4));
      d   = $urandom;
      if (sel <= 4) a = 32'($urandom_range(0, 255));
      else if (sel <= 7) begin
        a = IO | 32'($urandom_range(0, 6) * 4);
        if ($urandom_range(0, 3) != 0) t = T_W;
      end else if (sel == 8) a = IO | 32'($urandom_range(0, 31));
      else a = 32'h1000 + $urandom_range(0, 32'hEFFE_0000);
      if (a == A_TCMP) d = m_cycle + 32'($urandom_range(1, 40));
      if (a == A_CYC && $urandom_range(0, 1) == 0) d = m_tcmp - 32'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) sw_in = 16'($urandom);
      step(r, w, a, d, t, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Data-side memory responder for the five-stage pipeline CPU: the target end of the MEM-stage load/store interface. It holds word-organised data RAM with byte and halfword lane writes and returns sign- or zero-extended load data combinationally within the requesting MEM cycle. It also decodes a small memory-mapped I/O window: LEDs, 7-segment data, synchronised switches, a cycle counter, a compare timer and a sticky status register.

## Interface
Parameters:
- DEPTH, 1024: RAM depth in 32-bit words; power of two.
- MMIO_BASE, 32'hFFFF_0000: base of the I/O window; the window is 64 KiB, decoded on addr[31:16].

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- mem_w  input  1  store strobe from the MEM stage.
- addr  input  32  byte address from the MEM stage.
- wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- dm_type  input  3  access width/sign; encodings are the DMType macros in ctrl_encode_def.v (word, halfword, halfword_unsigned, byte, byte_unsigned).
- rdata  output  32  extended load data; combinational from addr, dm_type and state.
- sw_in  input  16  asynchronous board switches.
- led_out  output  16  LED register.
- seg_out  output  32  7-segment data register.
- timer_hit  output  1  STATUS[0].
- misalign_err  output  1  STATUS[1].

## Operation
- Region decode:
  - RAM when addr < DEPTH*4.
  - MMIO when addr[31:16] == MMIO_BASE[31:16].
  - Otherwise unmapped: reads return 0 and stores are dropped with no flag.
- RAM stores at the rising edge when mem_w=1:
  - Byte store: lane addr[1:0].
  - Halfword store: lanes selected by addr[1]; requires addr[0]=0.
  - Word store: requires addr[1:0]=0.
  - A misaligned store is suppressed and sets misalign_err.
- RAM loads: read the word at addr[31:2]. The lane is selected by addr[1:0] for bytes and by addr[1] for halves. Signed types sign-extend; unsigned types zero-extend. Misaligned loads ignore the low offending bits and are not flagged. Loads have no side effects.
- RAM contents are not cleared by rst.
- MMIO offsets (addr[15:0]):
  - 0x00 LED: RW; bits [15:0].
  - 0x04 SEG: RW; 32 bits.
  - 0x08 SW: RO; synchronised switches, zero-extended.
  - 0x0C CYCLE: RW; free-running +1 per cycle, wraps at 2^32; a store loads wdata.
  - 0x10 TCMP: RW compare value; 0 disables the timer.
  - 0x14 STATUS: bit0 timer_hit, bit1 misalign_err; write-1-to-clear.
  - Other offsets read 0; stores to them are ignored.
- MMIO accepts word stores only. A byte/half store to MMIO is dropped and sets misalign_err. MMIO reads ignore dm_type and return the full word. Stores to SW are ignored.
- Timer: timer_hit sets at the edge where CYCLE == TCMP and TCMP != 0, using the pre-increment value.
- Simultaneous events:
  - Set beats W1C clear in the same cycle.
  - A CYCLE store beats the increment.
  - A TCMP store in the match cycle does not suppress that cycle's set (the compare uses the old TCMP).
- Reset: LED, SEG, CYCLE, TCMP, STATUS, and both synchroniser stages go to 0. rst asserted together with mem_w blocks the store.

## Timing
- Stores take effect at the rising edge where mem_w=1.
- rdata is combinational, zero wait states, and valid in the same MEM cycle.
- A load in the cycle following a store to the same address returns the new data.
- There is no read-during-write hazard because reads are asynchronous: before the edge, rdata shows the old value.
- sw_in passes through two flops; a change is visible in SW reads after the second rising edge.
- CYCLE reads N in the N-th cycle after rst deasserts; the first cycle with rst=0 reads 0.
- timer_hit, misalign_err, led_out and seg_out are registered, with 0 cycles from register to output.
- Reset values of all outputs are 0. rdata after reset reflects RAM contents for RAM addresses, and 0 for MMIO and unmapped addresses.

## Test plan
- Sub-word writes and loads:
  - Stimulus: word store 0x8000_00FF to 0x10, then byte store 0x12 to 0x13, then loads from 0x13 and 0x10.
  - Required: word = 0x1200_00FF; byte-signed at 0x13 = 0x0000_0012; half-signed at 0x10 = 0x0000_00FF.
  - Then store half 0x8001 to 0x12. Required: half-signed at 0x12 = 0xFFFF_8001; half-unsigned at 0x12 = 0x0000_8001.
- Misalignment:
  - Word store to 0x22: memory unchanged and misalign_err=1 on the next cycle.
  - Then word store 0x2 to MMIO_BASE+0x14: misalign_err=0.
- Timer:
  - Stimulus: reset, then write TCMP=20.
  - Required: timer_hit rises exactly once, after the edge where CYCLE == 20. It stays high until a W1C of 0x1.
  - A W1C issued in the same cycle as a match leaves timer_hit=1.
- CYCLE write: storing 0xFFFF_FFFE to CYCLE gives reads 0xFFFF_FFFE, 0xFFFF_FFFF, 0x0000_0000 on successive cycles.
- Switch synchroniser: sw_in=0xA5A5 with back-to-back SW reads returns 0, then 0, then 0x0000_A5A5 (visible after the second edge).
- Reset mid-operation:
  - Stimulus: rst=1 concurrent with an LED store.
  - Required: led_out stays 0 and STATUS reads 0. Previously written RAM data is retained after rst deasserts.
  - An unmapped address (0x4000_0000 with DEPTH=1024) reads 0 and ignores stores.
